// File: rtl/mb_pkg.sv
// Shared types and bus-mode constants for the PSG bus sequencer.
// Phase order and AY-3-8910 style BDIR/BC encodings live here.
package mb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_GAP1,
    ST_WRITE,
    ST_GAP2
  } state_e;

  localparam logic [1:0] BUS_INACTIVE = 2'b00;
  localparam logic [1:0] BUS_WRITE    = 2'b10;
  localparam logic [1:0] BUS_LATCH    = 2'b11;

  function automatic state_e next_phase(state_e s);
    case (s)
      ST_LATCH: return ST_GAP1;
      ST_GAP1:  return ST_WRITE;
      ST_WRITE: return ST_GAP2;
      default:  return ST_IDLE;
    endcase
  endfunction

  function automatic logic [1:0] bus_mode(state_e s);
    case (s)
      ST_LATCH: return BUS_LATCH;
      ST_WRITE: return BUS_WRITE;
      default:  return BUS_INACTIVE;
    endcase
  endfunction

endpackage

// File: rtl/psg_rr_arbiter.sv
// Two-way round-robin grant between requesters A (0) and B (1).
// A tie goes to whichever requester was not granted last.
module psg_rr_arbiter #(
  parameter int FIRST_GRANT = 0
) (
  input  logic       clk_logic,
  input  logic       reset,
  input  logic [1:0] valid_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  logic last_q;
  logic last_d;

  // Grant decode and last-winner pointer update
  always_comb begin
    grant_o = 2'b00;
    unique case (1'b1)
      (valid_i == 2'b11): grant_o = last_q ? 2'b01 : 2'b10;
      default:            grant_o = valid_i;
    endcase
    last_d = last_q;
    if (advance_i) begin
      last_d = grant_o[1];
    end
  end

  // Pointer starts on the loser so FIRST_GRANT wins the first tie
  always_ff @(posedge clk_logic) begin
    if (reset) begin
      last_q <= (FIRST_GRANT == 0);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/psg_bus_sequencer.sv
// Serialises register writes from two requesters onto a pair of PSGs.
// Each write runs LATCH, GAP1, WRITE, GAP2 on the selected chip only.
module psg_bus_sequencer
  import mb_pkg::*;
#(
  parameter int HOLD_TICKS  = 1,
  parameter int FIRST_GRANT = 0
) (
  input  logic       clk_logic,
  input  logic       reset,
  input  logic       ce_i,
  input  logic       a_valid_i,
  output logic       a_ready_o,
  input  logic       a_chip_i,
  input  logic [3:0] a_reg_i,
  input  logic [7:0] a_data_i,
  input  logic       b_valid_i,
  output logic       b_ready_o,
  input  logic       b_chip_i,
  input  logic [3:0] b_reg_i,
  input  logic [7:0] b_data_i,
  output logic [1:0] psg_bdir_o,
  output logic [1:0] psg_bc_o,
  output logic [7:0] psg_da_o,
  output logic       busy_o,
  output logic       owner_o
);

  localparam logic [3:0] HOLD = 4'(HOLD_TICKS);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       chip_q, chip_d;
  logic [3:0] reg_q, reg_d;
  logic [7:0] data_q, data_d;
  logic       owner_q, owner_d;
  logic       busy_q, busy_d;
  logic [1:0] bdir_q, bdir_d;
  logic [1:0] bc_q, bc_d;
  logic [7:0] da_q, da_d;

  logic [1:0] grant;
  logic       idle;
  logic       xfer;
  logic [1:0] mode;

  psg_rr_arbiter #(
    .FIRST_GRANT(FIRST_GRANT)
  ) u_arb (
    .clk_logic(clk_logic),
    .reset    (reset),
    .valid_i  ({b_valid_i, a_valid_i}),
    .advance_i(xfer),
    .grant_o  (grant)
  );

  assign idle      = (state_q == ST_IDLE);
  assign a_ready_o = idle & grant[0] & ~reset;
  assign b_ready_o = idle & grant[1] & ~reset;
  assign xfer      = a_ready_o | b_ready_o;

  // Phase sequencing, request capture and next bus image
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chip_d  = chip_q;
    reg_d   = reg_q;
    data_d  = data_q;
    owner_d = owner_q;
    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          state_d = ST_LATCH;
          cnt_d   = HOLD;
          owner_d = grant[1];
          chip_d  = grant[1] ? b_chip_i : a_chip_i;
          reg_d   = grant[1] ? b_reg_i  : a_reg_i;
          data_d  = grant[1] ? b_data_i : a_data_i;
        end
      end
      default: begin
        if (ce_i) begin
          if (cnt_q == 4'd1) begin
            state_d = next_phase(state_q);
            cnt_d   = HOLD;
          end else begin
            cnt_d = 4'(cnt_q - 4'd1);
          end
        end
      end
    endcase

    mode           = bus_mode(state_d);
    bdir_d         = BUS_INACTIVE;
    bc_d           = BUS_INACTIVE;
    bdir_d[chip_d] = mode[1];
    bc_d[chip_d]   = mode[0];
    busy_d         = (state_d != ST_IDLE);
    da_d           = da_q;
    if (state_d == ST_LATCH) begin
      da_d = {4'h0, reg_d};
    end else if (state_d == ST_WRITE) begin
      da_d = data_d;
    end
  end

  // State and registered bus outputs
  always_ff @(posedge clk_logic) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      chip_q  <= 1'b0;
      reg_q   <= 4'h0;
      data_q  <= 8'h00;
      owner_q <= 1'b0;
      busy_q  <= 1'b0;
      bdir_q  <= BUS_INACTIVE;
      bc_q    <= BUS_INACTIVE;
      da_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chip_q  <= chip_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      bdir_q  <= bdir_d;
      bc_q    <= bc_d;
      da_q    <= da_d;
    end
  end

  assign psg_bdir_o = bdir_q;
  assign psg_bc_o   = bc_q;
  assign psg_da_o   = da_q;
  assign busy_o     = busy_q;
  assign owner_o    = owner_q;

endmodule

// File: tb/tb_psg_bus_sequencer.sv
// Directed bench for psg_bus_sequencer.
// Two instances: HOLD_TICKS=1 and HOLD_TICKS=3.
module tb_psg_bus_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic       rst, ce;
  logic       a_v, a_c, b_v, b_c;
  logic [3:0] a_r, b_r;
  logic [7:0] a_d, b_d;
  logic       a_rdy, b_rdy, busy, owner;
  logic [1:0] bdir, bcx;
  logic [7:0] da;

  logic       h_rst, h_ce;
  logic       ha_v, ha_c, hb_v, hb_c;
  logic [3:0] ha_r, hb_r;
  logic [7:0] ha_d, hb_d;
  logic       ha_rdy, hb_rdy, h_busy, h_owner;
  logic [1:0] h_bdir, h_bcx;
  logic [7:0] h_da;

  psg_bus_sequencer #(.HOLD_TICKS(1), .FIRST_GRANT(0)) dut1 (
    .clk_logic(clk), .reset(rst), .ce_i(ce),
    .a_valid_i(a_v), .a_ready_o(a_rdy), .a_chip_i(a_c),
    .a_reg_i(a_r), .a_data_i(a_d),
    .b_valid_i(b_v), .b_ready_o(b_rdy), .b_chip_i(b_c),
    .b_reg_i(b_r), .b_data_i(b_d),
    .psg_bdir_o(bdir), .psg_bc_o(bcx), .psg_da_o(da),
    .busy_o(busy), .owner_o(owner)
  );

  psg_bus_sequencer #(.HOLD_TICKS(3), .FIRST_GRANT(0)) dut3 (
    .clk_logic(clk), .reset(h_rst), .ce_i(h_ce),
    .a_valid_i(ha_v), .a_ready_o(ha_rdy), .a_chip_i(ha_c),
    .a_reg_i(ha_r), .a_data_i(ha_d),
    .b_valid_i(hb_v), .b_ready_o(hb_rdy), .b_chip_i(hb_c),
    .b_reg_i(hb_r), .b_data_i(hb_d),
    .psg_bdir_o(h_bdir), .psg_bc_o(h_bcx), .psg_da_o(h_da),
    .busy_o(h_busy), .owner_o(h_owner)
  );

  // Never two readys in one cycle on either instance
  always @(negedge clk) begin
    #2;
    n_chk++;
    if ((a_rdy && b_rdy) || (ha_rdy && hb_rdy)) begin
      n_fail++;
      $display("FAIL two_ready: got %b%b/%b%b want at most one",
               a_rdy, b_rdy, ha_rdy, hb_rdy);
    end
  end

  task automatic test_reset();
    rst = 1'b1; h_rst = 1'b1; a_v = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_chk++;
    if (a_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ready: got %b want 0", a_rdy);
    end
    n_chk++;
    if ({bdir, bcx, da, busy, owner} !== 14'h0) begin
      n_fail++;
      $display("FAIL rst_outs: got %h want 0",
               {bdir, bcx, da, busy, owner});
    end
    n_chk++;
    if ({h_bdir, h_bcx, h_da, h_busy, h_owner} !== 14'h0) begin
      n_fail++;
      $display("FAIL rst_outs3: got %h want 0",
               {h_bdir, h_bcx, h_da, h_busy, h_owner});
    end
    @(negedge clk);
    a_v = 1'b0; rst = 1'b0; h_rst = 1'b0;
  endtask

  task automatic test_single();
    logic [3:0] md [4];
    logic [7:0] dx [4];
    md[0] = 4'b0101; md[1] = 4'b0000;
    md[2] = 4'b0100; md[3] = 4'b0000;
    dx[0] = 8'h07; dx[1] = 8'h00; dx[2] = 8'h38; dx[3] = 8'h00;
    ce = 1'b0;
    a_v = 1'b1; a_c = 1'b0; a_r = 4'h7; a_d = 8'h38;
    #1;
    n_chk++;
    if ({a_rdy, b_rdy} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_accept: got %b want 10", {a_rdy, b_rdy});
    end
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 4; k++) begin
        n_chk++;
        if ({bdir, bcx} !== md[p] || busy !== 1'b1 || a_rdy !== 1'b0) begin
          n_fail++;
          $display("FAIL single_phase%0d: got %b/%b/%b want %b/1/0",
                   p, {bdir, bcx}, busy, a_rdy, md[p]);
        end
        if (p == 0 || p == 2) begin
          n_chk++;
          if (da !== dx[p]) begin
            n_fail++;
            $display("FAIL single_da%0d: got %h want %h", p, da, dx[p]);
          end
        end
        ce = (k == 3);
        if (p == 3 && k == 3) a_v = 1'b0;
        @(negedge clk);
        ce = 1'b0;
      end
    end
    n_chk++;
    if ({bdir, bcx, da, busy} !== {4'b0000, 8'h38, 1'b0}) begin
      n_fail++;
      $display("FAIL single_idle: got %h want %h",
               {bdir, bcx, da, busy}, {4'b0000, 8'h38, 1'b0});
    end
  endtask

  task automatic test_tie();
    logic eb;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ce = 1'b1;
    a_v = 1'b1; a_c = 1'b0; a_r = 4'hA; a_d = 8'hAA;
    b_v = 1'b1; b_c = 1'b1; b_r = 4'hB; b_d = 8'hBB;
    for (int i = 0; i < 3; i++) begin
      eb = (i == 1);
      #1;
      n_chk++;
      if ({a_rdy, b_rdy} !== (eb ? 2'b01 : 2'b10)) begin
        n_fail++;
        $display("FAIL tie_grant%0d: got %b want %b",
                 i, {a_rdy, b_rdy}, eb ? 2'b01 : 2'b10);
      end
      @(negedge clk);
      n_chk++;
      if ({owner, busy, bdir, bcx, da} !==
          {eb, 1'b1, eb ? 4'b1010 : 4'b0101, eb ? 8'h0B : 8'h0A}) begin
        n_fail++;
        $display("FAIL tie_latch%0d: got %h want %h", i,
                 {owner, busy, bdir, bcx, da},
                 {eb, 1'b1, eb ? 4'b1010 : 4'b0101, eb ? 8'h0B : 8'h0A});
      end
      if (i == 2) begin
        a_v = 1'b0; b_v = 1'b0;
      end
      @(negedge clk);
      @(negedge clk);
      n_chk++;
      if ({bdir, bcx, da} !== {eb ? 4'b1000 : 4'b0100,
                               eb ? 8'hBB : 8'hAA}) begin
        n_fail++;
        $display("FAIL tie_write%0d: got %h want %h", i,
                 {bdir, bcx, da},
                 {eb ? 4'b1000 : 4'b0100, eb ? 8'hBB : 8'hAA});
      end
      @(negedge clk);
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL tie_idle%0d: got %b want 0", i, busy);
      end
    end
    ce = 1'b0;
  endtask

  task automatic test_reset_mid();
    ce = 1'b1;
    a_v = 1'b1; a_c = 1'b1; a_r = 4'h3; a_d = 8'hA5;
    #1;
    n_chk++;
    if (a_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_accept: got %b want 1", a_rdy);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if ({bdir, bcx, da, a_rdy} !== {4'b1000, 8'hA5, 1'b0}) begin
      n_fail++;
      $display("FAIL rmid_write: got %h want %h",
               {bdir, bcx, da, a_rdy}, {4'b1000, 8'hA5, 1'b0});
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_chk++;
    if ({bdir, bcx, da, busy, a_rdy} !== 14'h0) begin
      n_fail++;
      $display("FAIL rmid_abort: got %h want 0",
               {bdir, bcx, da, busy, a_rdy});
    end
    rst = 1'b0;
    #1;
    n_chk++;
    if (a_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_reaccept: got %b want 1", a_rdy);
    end
    @(negedge clk);
    a_v = 1'b0;
    n_chk++;
    if ({owner, bdir, bcx, da} !== {1'b0, 4'b1010, 8'h03}) begin
      n_fail++;
      $display("FAIL rmid_latch: got %h want %h",
               {owner, bdir, bcx, da}, {1'b0, 4'b1010, 8'h03});
    end
    repeat (4) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_done: got %b want 0", busy);
    end
    ce = 1'b0;
  endtask

  task automatic test_capture();
    ce = 1'b1;
    a_v = 1'b1; a_c = 1'b0; a_r = 4'h5; a_d = 8'h5A;
    #1;
    n_chk++;
    if (a_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL cap_accept: got %b want 1", a_rdy);
    end
    @(negedge clk);
    a_v = 1'b0; a_c = 1'b1; a_r = 4'hF; a_d = 8'hFF;
    n_chk++;
    if ({bdir, bcx, da} !== {4'b0101, 8'h05}) begin
      n_fail++;
      $display("FAIL cap_latch: got %h want %h",
               {bdir, bcx, da}, {4'b0101, 8'h05});
    end
    @(negedge clk);
    n_chk++;
    if ({bdir, bcx} !== 4'b0000) begin
      n_fail++;
      $display("FAIL cap_gap1: got %b want 0000", {bdir, bcx});
    end
    @(negedge clk);
    n_chk++;
    if ({bdir, bcx, da} !== {4'b0100, 8'h5A}) begin
      n_fail++;
      $display("FAIL cap_write: got %h want %h",
               {bdir, bcx, da}, {4'b0100, 8'h5A});
    end
    @(negedge clk);
    n_chk++;
    if ({bdir, bcx, busy} !== 5'b00001) begin
      n_fail++;
      $display("FAIL cap_gap2: got %b want 00001", {bdir, bcx, busy});
    end
    @(negedge clk);
    n_chk++;
    if ({bdir, bcx, busy} !== 5'b00000) begin
      n_fail++;
      $display("FAIL cap_idle: got %b want 00000", {bdir, bcx, busy});
    end
    ce = 1'b0;
  endtask

  task automatic test_hold3();
    logic [3:0] md [4];
    logic [7:0] dx [4];
    int pulses;
    md[0] = 4'b1010; md[1] = 4'b0000;
    md[2] = 4'b1000; md[3] = 4'b0000;
    dx[0] = 8'h0D; dx[1] = 8'h00; dx[2] = 8'h0E; dx[3] = 8'h00;
    pulses = 0;
    h_ce = 1'b0;
    hb_v = 1'b1; hb_c = 1'b1; hb_r = 4'hD; hb_d = 8'h0E;
    #1;
    n_chk++;
    if ({ha_rdy, hb_rdy} !== 2'b01) begin
      n_fail++;
      $display("FAIL h3_accept: got %b want 01", {ha_rdy, hb_rdy});
    end
    @(negedge clk);
    n_chk++;
    if (h_owner !== 1'b1) begin
      n_fail++;
      $display("FAIL h3_owner: got %b want 1", h_owner);
    end
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 6; k++) begin
        n_chk++;
        if ({h_bdir, h_bcx} !== md[p] || h_busy !== 1'b1 ||
            hb_rdy !== 1'b0) begin
          n_fail++;
          $display("FAIL h3_phase%0d_%0d: got %b/%b/%b want %b/1/0",
                   p, k, {h_bdir, h_bcx}, h_busy, hb_rdy, md[p]);
        end
        if (p == 0 || p == 2) begin
          n_chk++;
          if (h_da !== dx[p]) begin
            n_fail++;
            $display("FAIL h3_da%0d: got %h want %h", p, h_da, dx[p]);
          end
        end
        h_ce = k[0];
        if (h_ce && h_busy) pulses++;
        if (p == 3 && k == 5) hb_v = 1'b0;
        @(negedge clk);
        h_ce = 1'b0;
      end
    end
    n_chk++;
    if (pulses != 12 || h_busy !== 1'b0 || {h_bdir, h_bcx} !== 4'b0000) begin
      n_fail++;
      $display("FAIL h3_end: got %0d/%b/%b want 12/0/0000",
               pulses, h_busy, {h_bdir, h_bcx});
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0;
    a_v = 1'b0; a_c = 1'b0; a_r = 4'h0; a_d = 8'h00;
    b_v = 1'b0; b_c = 1'b0; b_r = 4'h0; b_d = 8'h00;
    h_rst = 1'b1; h_ce = 1'b0;
    ha_v = 1'b0; ha_c = 1'b0; ha_r = 4'h0; ha_d = 8'h00;
    hb_v = 1'b0; hb_c = 1'b0; hb_r = 4'h0; hb_d = 8'h00;
    test_reset();
    test_single();
    test_tie();
    test_reset_mid();
    test_capture();
    test_hold3();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/psg_bus_sequencer.md
PSG_BUS_SEQUENCER -- requirements
Module: psg_bus_sequencer

Interface
REQ-001 SHALL have parameter HOLD_TICKS, default 1, giving ce_i pulses per bus phase (range 1..15).
REQ-002 SHALL have parameter FIRST_GRANT, default 0, naming the requester (0=A, 1=B) that wins the first tie after reset.
REQ-003 clk_logic  in  1  sole clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ce_i  in  1  bus-phase tick, driven from a2bus_if.phi1_negedge.
REQ-006 a_valid_i  in  1  requester A has a register write pending.
REQ-007 a_ready_o  out  1  requester A write accepted this cycle.
REQ-008 a_chip_i  in  1  target PSG for A (0=left, 1=right).
REQ-009 a_reg_i  in  4  PSG register number for A.
REQ-010 a_data_i  in  8  register data for A.
REQ-011 b_valid_i, b_ready_o, b_chip_i, b_reg_i, b_data_i: same as A, for requester B.
REQ-012 psg_bdir_o  out  2  BDIR per chip ([0]=left, [1]=right).
REQ-013 psg_bc_o  out  2  BC per chip.
REQ-014 psg_da_o  out  8  shared DA bus to both PSGs.
REQ-015 busy_o  out  1  sequencer is not IDLE.
REQ-016 owner_o  out  1  requester that owns the transfer in progress.

Function
REQ-017 FSM states: IDLE, LATCH ({BDIR,BC}=11, DA=reg zero-extended to 8 bits), GAP1 (00), WRITE (10, DA=data), GAP2 (00).
REQ-018 In IDLE, grant: one valid wins; with both valid, the requester not granted last wins.
REQ-019 a_ready_o/b_ready_o: combinational, high only in IDLE for the granted valid requester; transfer occurs on valid&&ready, regardless of ce_i.
REQ-020 At most one ready high per cycle; ready SHALL be 0 in every non-IDLE state.
REQ-021 On transfer, SHALL capture chip/reg/data, set owner_o, enter LATCH next cycle, load phase counter with HOLD_TICKS.
REQ-022 In non-IDLE states, counter decrements on each ce_i; a ce_i that finds counter=1 advances LATCH->GAP1->WRITE->GAP2->IDLE and reloads the counter.
REQ-023 Non-selected chip's BDIR/BC SHALL be 00 at all times; in IDLE both are 00 and psg_da_o holds its last value.
REQ-024 All outputs except the ready signals SHALL be registered.
REQ-025 Minimum transfer: 4*HOLD_TICKS ce_i pulses; next request may be accepted in the first IDLE cycle after GAP2.
REQ-026 ce_i held continuously high with HOLD_TICKS=1: exactly one clk_logic cycle per phase.
REQ-027 Inputs changing after acceptance SHALL not affect the transfer in progress.

Reset
REQ-028 Reset: state IDLE, psg_bdir_o=00, psg_bc_o=00, psg_da_o=00h, busy_o=0, owner_o=0, counter=0, last-grant pointer set so FIRST_GRANT wins the first tie.
REQ-029 Reset mid-transfer SHALL abort it, drive bus inactive on the next edge, and not assert any ready during reset.

Structure
REQ-030 Package mb_pkg SHALL hold the state enum and bus-mode constants BUS_INACTIVE=2'b00, BUS_WRITE=2'b10, BUS_LATCH=2'b11.
REQ-031 Two-way round-robin grant SHALL be sub-module psg_rr_arbiter (valid[1:0], grant[1:0], advance on transfer).

Verification
REQ-032 A: chip0, reg 7, data 38h, HOLD_TICKS=1, ce_i every 4th cycle -> left bus 11/07h, 00, 10/38h, 00, one ce_i each; right bus stays 00; a_ready_o high one cycle.
REQ-033 A and B valid in the same cycle, three times in a row -> grants A,B,A with FIRST_GRANT=0; never two readys in one cycle.
REQ-034 HOLD_TICKS=3, B: chip1, reg 0Dh, data 0Eh -> each phase spans exactly 3 ce_i pulses; busy_o high for 12 ce_i pulses.
REQ-035 Reset asserted during WRITE -> next cycle: bus 00, busy_o=0, DA=00h; held A request re-accepted after reset release.
REQ-036 A changes reg/data after acceptance, during LATCH -> bus shows the originally captured values throughout.
